// File: rtl/knn_seq_if.sv
// Query/reference handshake bundle for knn_seq: control, reference stream and sorted result.
interface knn_seq_if #(
  parameter int unsigned W = 32,
  parameter int unsigned K = 2
);
  logic           start;
  logic [W-1:0]   query;
  logic           ref_valid;
  logic [W-1:0]   ref_data;
  logic           ref_ready;
  logic           busy;
  logic           done;
  logic [W*K-1:0] o;

  // Requester side: issues queries and streams reference points
  modport master (
    output start, query, ref_valid, ref_data,
    input  ref_ready, busy, done, o
  );

  // Engine side: consumes the stream and reports the K nearest distances
  modport slave (
    input  start, query, ref_valid, ref_data,
    output ref_ready, busy, done, o
  );
endinterface

// File: rtl/knn_seq.sv
// Sequential k-nearest-distance engine: streams N reference points per query and
// keeps the K smallest |query - ref| values in an ascending insertion-sorted list.
module knn_seq #(
  parameter int unsigned W = 32,
  parameter int unsigned K = 2,
  parameter int unsigned N = 8
) (
  input  logic      clk,
  input  logic      rst,
  knn_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   query_q;
  logic [W-1:0]   slot      [K];
  logic [W-1:0]   slot_next [K];
  logic [W-1:0]   dist_c;
  logic           load;
  logic           xfer;
  logic           ref_ready;
  logic           busy;
  logic           done;
  logic [W*K-1:0] o_c;

  // Next-state decode: accept start in IDLE, count transfers in RUN, single DONE cycle
  always_comb begin
    state_next = state;
    load       = 1'b0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.ref_valid) begin
          xfer = 1'b1;
          if (cnt == CW'(N - 1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register plus status flags registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ref_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      ref_ready <= (state_next == RUN);
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
    end
  end

  // Absolute difference; subtracting the smaller operand cannot overflow
  always_comb begin
    dist_c = '0;
    if (query_q >= bus.ref_data) begin
      dist_c = query_q - bus.ref_data;
    end else begin
      dist_c = bus.ref_data - query_q;
    end
  end

  // Insertion sort step: strict-less compare keeps earlier ties in the lower slot
  always_comb begin
    for (int i = 0; i < int'(K); i++) begin
      slot_next[i] = slot[i];
    end
    for (int i = 0; i < int'(K); i++) begin
      if (i == 0) begin
        if (dist_c < slot[0]) begin
          slot_next[0] = dist_c;
        end
      end else if (dist_c < slot[i-1]) begin
        slot_next[i] = slot[i-1];
      end else if (dist_c < slot[i]) begin
        slot_next[i] = dist_c;
      end
    end
  end

  // Query latch, transfer counter and sorted slot list
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      query_q <= '0;
      cnt     <= '0;
      for (int i = 0; i < int'(K); i++) begin
        slot[i] <= '1;
      end
    end else if (load) begin
      query_q <= bus.query;
      cnt     <= '0;
      for (int i = 0; i < int'(K); i++) begin
        slot[i] <= '1;
      end
    end else if (xfer) begin
      cnt <= cnt + CW'(1);
      for (int i = 0; i < int'(K); i++) begin
        slot[i] <= slot_next[i];
      end
    end
  end

  // Flatten slots onto the result bus, slot 0 in the least significant lane
  always_comb begin
    o_c = '0;
    for (int i = 0; i < int'(K); i++) begin
      o_c[W*i +: W] = slot[i];
    end
  end

  assign bus.o         = o_c;
  assign bus.ref_ready = ref_ready;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_knn_seq.sv
// Scoreboard bench for knn_seq: three instances (K=1,2,4; W=8, N=4) share one stimulus stream.
module tb_knn_seq;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  typedef struct packed {
    logic [7:0]  k1;
    logic [15:0] k2;
    logic [31:0] k4;
  } exp_t;

  logic clk;
  logic rst;
  logic start;
  logic [W-1:0] query;
  logic ref_valid;
  logic [W-1:0] ref_data;

  int checks;
  int errors;
  exp_t exp_q[$];

  knn_seq_if #(.W(W), .K(1)) if_k1 ();
  knn_seq_if #(.W(W), .K(2)) if_k2 ();
  knn_seq_if #(.W(W), .K(4)) if_k4 ();

  assign if_k1.start = start;  assign if_k1.query = query;
  assign if_k1.ref_valid = ref_valid;  assign if_k1.ref_data = ref_data;
  assign if_k2.start = start;  assign if_k2.query = query;
  assign if_k2.ref_valid = ref_valid;  assign if_k2.ref_data = ref_data;
  assign if_k4.start = start;  assign if_k4.query = query;
  assign if_k4.ref_valid = ref_valid;  assign if_k4.ref_data = ref_data;

  knn_seq #(.W(W), .K(1), .N(N)) dut_k1 (.clk(clk), .rst(rst), .bus(if_k1));
  knn_seq #(.W(W), .K(2), .N(N)) dut_k2 (.clk(clk), .rst(rst), .bus(if_k2));
  knn_seq #(.W(W), .K(4), .N(N)) dut_k4 (.clk(clk), .rst(rst), .bus(if_k4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_q(input logic [W-1:0] q);
    start = 1'b1;
    query = q;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d);
    ref_valid = 1'b1;
    ref_data  = d;
    step();
    ref_valid = 1'b0;
    ref_data  = 8'hEE;
  endtask

  // Called #1 after the Nth transfer edge: done must be up now and gone one cycle later
  task automatic check_finish(input string tag);
    check({tag, "_done_latency"}, 32'(if_k2.done), 32'd1);
    step();
    check({tag, "_done_single"}, 32'(if_k2.done), 32'd0);
    check({tag, "_idle_busy"}, 32'(if_k2.busy), 32'd0);
    check({tag, "_idle_ready"}, 32'(if_k2.ref_ready), 32'd0);
  endtask

  task automatic push(input logic [7:0] e1, input logic [15:0] e2, input logic [31:0] e4);
    exp_t e;
    e.k1 = e1;
    e.k2 = e2;
    e.k4 = e4;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse consumes one scoreboard entry
  always @(negedge clk) begin
    if (!rst && (if_k1.done || if_k2.done || if_k4.done)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result pending at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_aligned", 32'({if_k1.done, if_k2.done, if_k4.done}), 32'h7);
        check("o_k1", 32'(if_k1.o), 32'(e.k1));
        check("o_k2", 32'(if_k2.o), 32'(e.k2));
        check("o_k4", if_k4.o, e.k4);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    query = '0;
    ref_valid = 1'b0;
    ref_data = '0;

    #2;
    check("rst_o_k1", 32'(if_k1.o), 32'hFF);
    check("rst_o_k2", 32'(if_k2.o), 32'hFFFF);
    check("rst_o_k4", if_k4.o, 32'hFFFFFFFF);
    check("rst_busy", 32'(if_k2.busy), 32'd0);
    check("rst_ready", 32'(if_k2.ref_ready), 32'd0);
    check("rst_done", 32'(if_k2.done), 32'd0);
    step();
    step();
    rst = 1'b0;

    // Basic back-to-back run: distances 10,20,2,40
    start_q(8'd50);
    check("basic_ready", 32'(if_k2.ref_ready), 32'd1);
    check("basic_busy", 32'(if_k2.busy), 32'd1);
    push(8'h02, 16'h0A02, 32'h28140A02);
    send(8'd40); send(8'd70); send(8'd52); send(8'd10);
    check_finish("basic");
    step(); step();
    check("hold_in_idle", 32'(if_k2.o), 32'h0A02);

    // Ties: distances 5,5,255,3
    start_q(8'd0);
    push(8'h03, 16'h0503, 32'hFF050503);
    send(8'd5); send(8'd5); send(8'd255); send(8'd3);
    check_finish("ties");

    // Saturation: every distance is 255, equal to the all-ones fill
    start_q(8'd255);
    push(8'hFF, 16'hFFFF, 32'hFFFFFFFF);
    send(8'd0); send(8'd0); send(8'd0); send(8'd0);
    check_finish("sat");

    // Backpressure: valid pattern 1,0,0,1,1,0,1; distances 10,20,1,1
    begin
      logic       vpat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [7:0] refs [4] = '{8'd90, 8'd120, 8'd101, 8'd99};
      int r;
      r = 0;
      start_q(8'd100);
      push(8'h01, 16'h0101, 32'h140A0101);
      for (int c = 0; c < 7; c++) begin
        ref_valid = vpat[c];
        ref_data  = vpat[c] ? refs[r] : 8'h00;
        if (vpat[c]) r++;
        step();
      end
      ref_valid = 1'b0;
      check_finish("bp");
    end

    // Start pulse with query=0 during RUN must not disturb the basic result
    start_q(8'd50);
    push(8'h02, 16'h0A02, 32'h28140A02);
    send(8'd40);
    start = 1'b1;
    query = 8'd0;
    step();
    start = 1'b0;
    send(8'd70);
    start = 1'b1;
    send(8'd52);
    start = 1'b0;
    send(8'd10);
    check_finish("ign_start");

    // Asynchronous reset after two transfers abandons the query immediately
    start_q(8'd50);
    send(8'd40); send(8'd70);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_o_k1", 32'(if_k1.o), 32'hFF);
    check("midrst_o_k2", 32'(if_k2.o), 32'hFFFF);
    check("midrst_o_k4", if_k4.o, 32'hFFFFFFFF);
    check("midrst_busy", 32'(if_k2.busy), 32'd0);
    check("midrst_ready", 32'(if_k2.ref_ready), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_idle", 32'(if_k2.busy), 32'd0);

    // Start in the first cycle after release, then stall with no data
    rst = 1'b1;
    step();
    rst = 1'b0;
    start_q(8'd50);
    step(); step(); step(); step(); step();
    check("stall_busy", 32'(if_k2.busy), 32'd1);
    check("stall_ready", 32'(if_k2.ref_ready), 32'd1);
    check("stall_o", 32'(if_k2.o), 32'hFFFF);
    push(8'h02, 16'h0A02, 32'h28140A02);
    send(8'd40); send(8'd70); send(8'd52); send(8'd10);
    check_finish("after_rst");

    step(); step(); step();
    check("pending_results", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/knn_seq.md
KNN_SEQ -- requirements
Module: knn_seq

Interface
REQ-001 SHALL have parameter W, default 32, unsigned data/distance width in bits.
REQ-002 SHALL have parameter K, default 2, number of nearest distances retained; legal range 1..N.
REQ-003 SHALL have parameter N, default 8, number of reference points per query; N>=2.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  begins a query when the block is idle.
REQ-007 SHALL have port query  input  W  query point, sampled on an accepted start.
REQ-008 SHALL have port ref_valid  input  1  ref_data is valid.
REQ-009 SHALL have port ref_data  input  W  reference point.
REQ-010 SHALL have port ref_ready  output  1  block accepts ref_data this cycle.
REQ-011 SHALL have port busy  output  1  a query is in progress (RUN or DONE).
REQ-012 SHALL have port done  output  1  single-cycle pulse; result complete.
REQ-013 SHALL have port o  output  W*K  K smallest distances, ascending; slot i at o[W*(i+1)-1:W*i], slot 0 smallest.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 IDLE: start=1 SHALL latch query, set all K slots to all-ones, clear the accept counter, and enter RUN next cycle.
REQ-016 RUN: ref_ready SHALL be 1; ref_ready SHALL be 0 in IDLE and DONE.
REQ-017 A transfer SHALL occur on ref_valid & ref_ready; ref_data SHALL be ignored otherwise.
REQ-018 Distance SHALL be the unsigned absolute difference |query - ref_data|, W bits wide, computed without overflow.
REQ-019 Each transfer SHALL insert its distance d into the sorted list on the same clock edge.
REQ-020 Insertion rule: slot i takes d if d < slot[i] and (i==0 or d >= slot[i-1]); slot i takes slot[i-1] if d < slot[i-1]; otherwise slot i holds; slot K-1's old value is discarded.
REQ-021 Ties SHALL keep the earlier-arrived distance in the lower slot (strict-less insertion).
REQ-022 The accept counter SHALL be ceil(log2(N+1)) bits wide and increment once per transfer.
REQ-023 The Nth transfer SHALL move the FSM to DONE on the same edge; no further transfers SHALL be accepted.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 Latency: done SHALL assert the cycle after the Nth transfer; minimum start-to-done is N+1 cycles.
REQ-026 o SHALL be driven directly from the slot registers and hold its value in IDLE until the next accepted start.
REQ-027 start SHALL be ignored in RUN and DONE; start with no following ref_valid SHALL leave the block in RUN indefinitely.
REQ-028 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-029 Gaps in ref_valid SHALL stall the counter without changing the result.

Reset
REQ-030 rst=1 SHALL, without waiting for a clock edge, force state IDLE, counter 0, ref_ready=0, busy=0, done=0, all slots all-ones (o = all ones) and the query register 0.
REQ-031 rst asserted mid-RUN SHALL abandon the query; after rst deasserts the block SHALL need a new start.
REQ-032 A start in the first cycle after rst deasserts SHALL be accepted normally.

Verification (W=8, K=2, N=4)
REQ-033 Basic: start with query=50, refs 40,70,52,10 back-to-back -> done 1 cycle after the 4th transfer, o slot0=2, slot1=10 (o=16'h0A02).
REQ-034 Ties and saturation: query=0, refs 5,5,255,3 -> slot0=3, slot1=5; query=255, refs 0,0,0,0 -> o=16'hFFFF.
REQ-035 Backpressure: query=100, ref_valid toggled 1,0,0,1,1,0,1 with refs 90,120,101,99 -> the same result as the back-to-back run, slot0=1, slot1=1; done once only.
REQ-036 Ignored start: a start pulse with query=0 during RUN of the basic case -> the result is unchanged (16'h0A02).
REQ-037 Reset mid-operation: rst pulsed after 2 transfers -> o=16'hFFFF, busy=0 and ref_ready=0 at once; a new start then gives the correct result.
REQ-038 K=1 and K=N configurations: repeat the basic case -> K=1 o=8'h02; K=4 o={40,20,10,2} in slots 3..0.
